// File: rtl/mem_resp_stage_pkg.sv
// Shared constants for the MEM response stage: state encoding, load-size codes
// and the packed widths of the entry carried into MEM and the bundle sent to WB.
package mem_resp_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_READY   = 2'd2,
    ST_DISCARD = 2'd3
  } stage_state_e;

  localparam logic [1:0] LD_BYTE   = 2'b00;
  localparam logic [1:0] LD_HALF   = 2'b01;
  localparam logic [1:0] LD_WORD   = 2'b10;
  localparam logic [1:0] LD_DOUBLE = 2'b11;

  // to_MEM payload: pc, alu_result, ld, ld_size, ld_signed, dest, gr_we, ex
  function automatic int to_mem_w(input int xlen, input int dest_w, input int pc_w);
    return pc_w + xlen + 1 + 2 + 1 + dest_w + 1 + 1;
  endfunction

  // to_WB payload: pc, dest, result, gr_we, ex
  function automatic int to_wb_w(input int xlen, input int dest_w, input int pc_w);
    return pc_w + dest_w + xlen + 1 + 1;
  endfunction

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Load lane select and zero/sign extension for an XLEN-wide memory word.
module load_align
  import mem_resp_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           data,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                size,
  input  logic                      sign_ext,
  output logic [XLEN-1:0]           result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            msb;

  assign shifted = data >> {offset, 3'b000};

  always_comb begin
    mask = '1;
    msb  = 1'b0;
    unique case (size)
      LD_BYTE:   begin mask = XLEN'(8'hFF);         msb = shifted[7];  end
      LD_HALF:   begin mask = XLEN'(16'hFFFF);      msb = shifted[15]; end
      LD_WORD:   begin mask = XLEN'(32'hFFFF_FFFF); msb = shifted[31]; end
      LD_DOUBLE: begin mask = '1;                   msb = 1'b0;        end
    endcase
    result = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_resp_stage.sv
// Single-entry MEM stage: holds one instruction, waits for its data-memory
// response, and presents the final result to WB and the forwarding bus.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEST_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_ex,
  input  logic              EX_to_MEM_valid,
  output logic              MEM_allow_in,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              in_req,
  input  logic              in_ld,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_gr_we,
  input  logic              in_ex,
  input  logic              data_ok,
  input  logic [XLEN-1:0]   data_rdata,
  input  logic              WB_allow_in,
  output logic              MEM_to_WB_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DEST_W-1:0] out_dest,
  output logic [XLEN-1:0]   out_result,
  output logic              out_gr_we,
  output logic              out_ex,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [XLEN-1:0]   fwd_data,
  output logic              fwd_stall
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int MEM_W = to_mem_w(XLEN, DEST_W, PC_W);
  localparam int WB_W  = to_wb_w(XLEN, DEST_W, PC_W);

  stage_state_e     state_q, state_d;
  logic [MEM_W-1:0] entry_q, entry_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;

  logic [PC_W-1:0]   e_pc;
  logic [XLEN-1:0]   e_alu;
  logic              e_ld;
  logic [1:0]        e_ld_size;
  logic              e_ld_signed;
  logic [DEST_W-1:0] e_dest;
  logic              e_gr_we;
  logic              e_ex;

  logic              accept;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   result;
  logic [WB_W-1:0]   wb_bus;

  assign {e_pc, e_alu, e_ld, e_ld_size, e_ld_signed, e_dest, e_gr_we, e_ex} = entry_q;

  assign MEM_allow_in = (state_q == ST_EMPTY) || (state_q == ST_READY && WB_allow_in);
  assign accept       = EX_to_MEM_valid && MEM_allow_in && !wb_ex;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    rdata_d = rdata_q;
    if (accept) begin
      entry_d = {in_pc, in_alu_result, in_ld, in_ld_size, in_ld_signed,
                 in_dest, in_gr_we, in_ex};
    end
    if (state_q == ST_WAIT && data_ok) begin
      rdata_d = data_rdata;
    end
    // A flush kills the entry; an outstanding request still owes us one response.
    if (wb_ex) begin
      unique case (state_q)
        ST_WAIT:    state_d = data_ok ? ST_EMPTY : ST_DISCARD;
        ST_DISCARD: state_d = data_ok ? ST_EMPTY : ST_DISCARD;
        default:    state_d = ST_EMPTY;
      endcase
    end else begin
      unique case (state_q)
        ST_EMPTY:   if (accept) state_d = in_req ? ST_WAIT : ST_READY;
        ST_WAIT:    if (data_ok) state_d = ST_READY;
        ST_READY:   if (WB_allow_in) state_d = accept ? (in_req ? ST_WAIT : ST_READY) : ST_EMPTY;
        ST_DISCARD: if (data_ok) state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    rdata_q <= rdata_d;
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .data     (rdata_q),
    .offset   (e_alu[OFF_W-1:0]),
    .size     (e_ld_size),
    .sign_ext (e_ld_signed),
    .result   (load_data)
  );

  assign result = e_ld ? load_data : e_alu;
  assign wb_bus = {e_pc, e_dest, result, e_gr_we, e_ex};
  assign {out_pc, out_dest, out_result, out_gr_we, out_ex} = wb_bus;

  assign MEM_to_WB_valid = (state_q == ST_READY);
  assign fwd_dest  = (state_q == ST_WAIT || state_q == ST_READY) ? e_dest : '0;
  assign fwd_stall = (state_q == ST_WAIT) && e_ld;
  assign fwd_data  = result;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Randomized bench for mem_resp_stage (XLEN=32 and XLEN=64 instances) against a
// transaction-level reference of load extraction and stage occupancy.
module tb_mem_resp_stage;

  logic        clk = 1'b0;
  logic        reset, wbEx, v32, v64, inReq, inLd, inLdSigned, inGrWe, inEx, dataOk, wbAllowIn;
  logic [31:0] inPc, alu32, rdata32;
  logic [63:0] alu64, rdata64;
  logic [1:0]  inLdSize;
  logic [4:0]  inDest;

  logic        allow32, valid32, outGrWe32, outEx32, fwdStall32;
  logic [31:0] outPc32, res32, fwdData32;
  logic [4:0]  outDest32, fwdDest32;

  logic        allow64, valid64, outGrWe64, outEx64, fwdStall64;
  logic [31:0] outPc64;
  logic [63:0] res64, fwdData64;
  logic [4:0]  outDest64, fwdDest64;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mem_resp_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .wb_ex(wbEx), .EX_to_MEM_valid(v32), .MEM_allow_in(allow32),
    .in_pc(inPc), .in_alu_result(alu32), .in_req(inReq), .in_ld(inLd), .in_ld_size(inLdSize),
    .in_ld_signed(inLdSigned), .in_dest(inDest), .in_gr_we(inGrWe), .in_ex(inEx),
    .data_ok(dataOk), .data_rdata(rdata32), .WB_allow_in(wbAllowIn), .MEM_to_WB_valid(valid32),
    .out_pc(outPc32), .out_dest(outDest32), .out_result(res32), .out_gr_we(outGrWe32),
    .out_ex(outEx32), .fwd_dest(fwdDest32), .fwd_data(fwdData32), .fwd_stall(fwdStall32)
  );

  mem_resp_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .wb_ex(wbEx), .EX_to_MEM_valid(v64), .MEM_allow_in(allow64),
    .in_pc(inPc), .in_alu_result(alu64), .in_req(inReq), .in_ld(inLd), .in_ld_size(inLdSize),
    .in_ld_signed(inLdSigned), .in_dest(inDest), .in_gr_we(inGrWe), .in_ex(inEx),
    .data_ok(dataOk), .data_rdata(rdata64), .WB_allow_in(wbAllowIn), .MEM_to_WB_valid(valid64),
    .out_pc(outPc64), .out_dest(outDest64), .out_result(res64), .out_gr_we(outGrWe64),
    .out_ex(outEx64), .fwd_dest(fwdDest64), .fwd_data(fwdData64), .fwd_stall(fwdStall64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Loaded value as plain arithmetic: pick the addressed bytes, then wrap to signed if asked.
  function automatic logic [63:0] refLoad(input logic [63:0] rdata, input int xlen,
                                          input logic [63:0] addr, input logic [1:0] sz,
                                          input logic sg);
    longint unsigned v, lim;
    int nb, off;
    nb  = 1 << sz;
    off = int'(addr % 64'(xlen / 8));
    v   = rdata >> (8 * off);
    if (nb < 8) begin
      lim = 64'd1 << (8 * nb);
      v   = v % lim;
      if (sg && v >= lim / 2) v = v - lim;
    end
    if (xlen == 32) v = v % (64'd1 << 32);
    return v;
  endfunction

  function automatic logic [63:0] alignAddr(input logic [63:0] a, input logic [1:0] sz);
    return a & ~((64'd1 << sz) - 64'd1);
  endfunction

  // kind: 0 ALU, 1 load, 2 store. flush: 0 none, 1 during the wait, 2 together with data_ok.
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] sz,
                               input logic sg, input logic [31:0] rdata, input int delay,
                               input int stall, input int flush);
    logic [31:0] pc, expv;
    logic [63:0] t;
    logic [4:0]  dst;
    logic        ex, gwe;
    bit          flushed;
    pc = $urandom; dst = 5'($urandom); ex = 1'($urandom); gwe = (kind != 2); flushed = 0;
    t = refLoad({32'h0, rdata}, 32, {32'h0, addr}, sz, sg);
    expv = (kind == 1) ? t[31:0] : addr;
    inPc = pc; alu32 = addr; inReq = (kind != 0); inLd = (kind == 1); inLdSize = sz;
    inLdSigned = sg; inDest = dst; inGrWe = gwe; inEx = ex; wbAllowIn = 1'b1; v32 = 1'b1;
    #1 checkOutput("allow_empty", allow32, 1);
    @(posedge clk); #1;
    v32 = 1'b0; alu32 = ~addr; inDest = ~dst; inPc = ~pc; inLd = ~inLd; inEx = ~ex;
    if (kind != 0) begin
      for (int i = 0; i < delay; i++) begin
        wbEx = (flush == 1 && i == 0);
        #1;
        checkOutput("wait_valid", valid32, 0);
        checkOutput("wait_allow", allow32, 0);
        checkOutput("wait_stall", fwdStall32, (kind == 1 && !flushed));
        checkOutput("wait_fwd_dest", fwdDest32, flushed ? 5'd0 : dst);
        @(posedge clk); #1;
        if (wbEx) flushed = 1;
        wbEx = 1'b0;
      end
      dataOk = 1'b1; rdata32 = rdata; wbEx = (flush == 2);
      #1 checkOutput("resp_allow", allow32, 0);
      @(posedge clk); #1;
      dataOk = 1'b0; rdata32 = $urandom; wbEx = 1'b0;
      if (flush != 0) begin
        #1;
        checkOutput("flush_valid", valid32, 0);
        checkOutput("flush_allow", allow32, 1);
        checkOutput("flush_fwd_dest", fwdDest32, 0);
        return;
      end
    end
    wbAllowIn = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) wbAllowIn = 1'b1;
      #1;
      checkOutput("out_valid", valid32, 1);
      checkOutput("out_result", res32, expv);
      checkOutput("out_pc", outPc32, pc);
      checkOutput("out_dest", outDest32, dst);
      checkOutput("out_gr_we", outGrWe32, gwe);
      checkOutput("out_ex", outEx32, ex);
      checkOutput("fwd_data", fwdData32, expv);
      checkOutput("fwd_dest", fwdDest32, dst);
      checkOutput("fwd_stall_ready", fwdStall32, 0);
      checkOutput("ready_allow", allow32, (i == stall));
      @(posedge clk); #1;
    end
    #1 checkOutput("drained", valid32, 0);
  endtask

  task automatic applyLoad64(input logic [63:0] addr, input logic [1:0] sz, input logic sg,
                             input logic [63:0] rdata);
    logic [63:0] expv;
    logic [4:0]  dst;
    expv = refLoad(rdata, 64, addr, sz, sg);
    dst = 5'($urandom);
    inReq = 1'b1; inLd = 1'b1; inLdSize = sz; inLdSigned = sg; inDest = dst;
    alu64 = addr; v64 = 1'b1; wbAllowIn = 1'b1;
    #1 checkOutput("d64_allow", allow64, 1);
    @(posedge clk); #1;
    v64 = 1'b0; dataOk = 1'b1; rdata64 = rdata;
    #1 checkOutput("d64_stall", fwdStall64, 1);
    @(posedge clk); #1;
    dataOk = 1'b0; rdata64 = '0;
    #1;
    checkOutput("d64_valid", valid64, 1);
    checkOutput("d64_result", res64, expv);
    checkOutput("d64_fwd_data", fwdData64, expv);
    checkOutput("d64_fwd_dest", fwdDest64, dst);
    @(posedge clk); #1;
  endtask

  initial begin
    int kind, delay, stall, flush;
    logic [1:0]  sz;
    logic [31:0] addr, alu;
    logic [63:0] a64;
    logic        vv;

    reset = 1'b1; wbEx = 1'b0; v32 = 1'b0; v64 = 1'b0; inReq = 1'b0; inLd = 1'b0;
    inLdSigned = 1'b0; inGrWe = 1'b0; inEx = 1'b0; dataOk = 1'b0; wbAllowIn = 1'b1;
    inPc = '0; alu32 = '0; rdata32 = '0; alu64 = '0; rdata64 = '0; inLdSize = '0; inDest = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", valid32, 0);
    checkOutput("reset_fwd_dest", fwdDest32, 0);
    checkOutput("reset_fwd_stall", fwdStall32, 0);
    checkOutput("reset_allow", allow32, 1);
    reset = 1'b0;

    applyStimulus(0, 32'h0000_1234, 2'd0, 1'b0, 32'h0, 0, 0, 0);
    applyStimulus(1, 32'h1000_0003, 2'd0, 1'b1, 32'h80FF_FFFF, 3, 0, 0);
    applyStimulus(1, 32'h2000_0002, 2'd1, 1'b0, 32'hBEEF_0000, 1, 4, 0);
    applyStimulus(1, 32'h3000_0000, 2'd2, 1'b0, 32'h1234_5678, 2, 0, 1);
    applyStimulus(0, 32'h0000_00AA, 2'd0, 1'b0, 32'h0, 0, 0, 0);
    applyStimulus(1, 32'h4000_0001, 2'd0, 1'b1, 32'hFFFF_7FFF, 1, 0, 2);
    applyStimulus(1, 32'h5000_0000, 2'd1, 1'b1, 32'h0000_8001, 0, 1, 0);

    repeat (40) begin
      kind  = $urandom_range(0, 2);
      sz    = 2'($urandom_range(0, 2));
      addr  = 32'(alignAddr({32'h0, $urandom}, sz));
      delay = $urandom_range(0, 4);
      stall = $urandom_range(0, 3);
      flush = (kind != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (flush == 1 && delay == 0) delay = 1;
      applyStimulus(kind, addr, sz, 1'($urandom), $urandom, delay, stall, flush);
    end

    // Back-to-back ALU entries: each accepted entry appears exactly one cycle later.
    wbAllowIn = 1'b1; inReq = 1'b0; inLd = 1'b0;
    for (int c = 0; c < 12; c++) begin
      vv  = (c < 6) || (c < 10 && $urandom_range(0, 2) != 0);
      alu = $urandom;
      v32 = vv; alu32 = alu;
      #1 checkOutput("burst_allow", allow32, 1);
      @(posedge clk); #1;
      v32 = 1'b0;
      checkOutput("burst_valid", valid32, vv);
      if (vv) checkOutput("burst_result", res32, alu);
    end

    applyLoad64(64'h0000_0000_0000_1000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
    repeat (12) begin
      sz  = 2'($urandom_range(0, 3));
      a64 = alignAddr({$urandom, $urandom}, sz);
      applyLoad64(a64, sz, 1'($urandom), {$urandom, $urandom});
    end

    // Reset while a load is outstanding abandons it.
    inReq = 1'b1; inLd = 1'b1; inDest = 5'd7; alu32 = 32'h100; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    #1 checkOutput("pre_reset_stall", fwdStall32, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("wait_reset_valid", valid32, 0);
    checkOutput("wait_reset_allow", allow32, 1);
    checkOutput("wait_reset_stall", fwdStall32, 0);
    checkOutput("wait_reset_fwd_dest", fwdDest32, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and memory data width; legal values 32 or 64.
REQ-002 Parameter DEST_W, default 5, register-index width.
REQ-003 Parameter PC_W, default 32, PC width.
REQ-004 Clock and reset SHALL be fixed as follows: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 wb_ex  in  1  exception/flush from WB.
REQ-008 EX_to_MEM_valid  in  1  upstream entry valid.
REQ-009 MEM_allow_in  out  1  stage accepts an entry this cycle.
REQ-010 in_pc  in  PC_W  PC of entry.
REQ-011 in_alu_result  in  XLEN  ALU result or memory address.
REQ-012 in_req  in  1  EX issued a data-memory request (load or store) for this entry.
REQ-013 in_ld  in  1  entry is a load.
REQ-014 in_ld_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
REQ-015 in_ld_signed  in  1  sign-extend load data.
REQ-016 in_dest, in_gr_we, in_ex  in  DEST_W, 1, 1  destination register, write enable, exception flag.
REQ-017 data_ok, data_rdata  in  1, XLEN  memory response strobe and read data.
REQ-018 WB_allow_in  in  1  downstream ready.
REQ-019 MEM_to_WB_valid  out  1  output entry valid.
REQ-020 out_pc, out_dest, out_result, out_gr_we, out_ex  out  PC_W, DEST_W, XLEN, 1, 1  registered entry fields plus final result.
REQ-021 fwd_dest, fwd_data, fwd_stall  out  DEST_W, XLEN, 1  forwarding bus; fwd_stall=1 means fwd_data is not yet valid (load pending).

Function
REQ-022 States SHALL be EMPTY, WAIT, READY and DISCARD.
REQ-023 An entry SHALL be accepted when EX_to_MEM_valid and MEM_allow_in are both high.
REQ-024 On acceptance: next state is WAIT if in_req=1, otherwise READY.
REQ-025 MEM_allow_in SHALL equal (state==EMPTY) or (state==READY and WB_allow_in), and SHALL be 0 in WAIT and DISCARD.
REQ-026 In WAIT, data_ok=1 SHALL latch data_rdata into an internal XLEN buffer and move the state to READY; a response arriving while WB is stalled is held, never lost.
REQ-027 MEM_to_WB_valid SHALL be 1 only in READY; transfer completes when MEM_to_WB_valid and WB_allow_in are both high.
REQ-028 On transfer, next state is EMPTY, or WAIT/READY if a new entry is accepted in the same cycle.
REQ-029 Minimum latency: an entry with in_req=0 accepted at cycle N is presented at N+1; a request entry is presented the cycle after data_ok.
REQ-030 Load extraction SHALL select lanes by in_alu_result[log2(XLEN/8)-1:0] and zero- or sign-extend per in_ld_signed; misaligned offsets are out of scope (flagged upstream).
REQ-031 out_result SHALL be the extended load data when in_ld=1, otherwise in_alu_result.
REQ-032 fwd_dest SHALL be in_dest gated to 0 in EMPTY/DISCARD; fwd_stall SHALL be 1 in WAIT when in_ld=1; fwd_data SHALL equal out_result.
REQ-033 wb_ex=1 SHALL clear the entry: WAIT becomes DISCARD; EMPTY and READY become EMPTY; no entry is accepted that cycle.
REQ-034 In DISCARD, the next data_ok SHALL be consumed and dropped, then the state becomes EMPTY.
REQ-035 wb_ex and data_ok in the same cycle while in WAIT SHALL go directly to EMPTY.

Reset
REQ-036 Reset SHALL force state EMPTY, MEM_to_WB_valid=0, fwd_dest=0 and fwd_stall=0; datapath registers need not be reset.
REQ-037 Reset asserted during WAIT SHALL abandon the response; the system resets memory simultaneously.

Structure
REQ-038 State encoding, load-size codes and the to_MEM/to_WB packed widths SHALL live in the shared constants header.
REQ-039 The lane-select and extension logic SHALL be one sub-module, load_align, parameterised by XLEN.

Verification
REQ-040 ALU entry, result 0x1234, WB_allow_in=1 -> MEM_to_WB_valid on the next cycle with out_result=0x1234.
REQ-041 Signed byte load, address 0x...03, data_ok after 3 cycles with rdata 0x80FF_FFFF -> out_result 0xFFFF_FF80; fwd_stall=1 during the wait.
REQ-042 Unsigned half load, address offset 2, rdata 0xBEEF_0000, WB_allow_in=0 for 4 cycles -> out_result 0x0000_BEEF held stable and MEM_allow_in=0 throughout.
REQ-043 wb_ex while in WAIT, data_ok 2 cycles later -> no MEM_to_WB_valid, MEM_allow_in=0 until that data_ok, then a new entry is accepted.
REQ-044 XLEN=64, double load, rdata 0x0123_4567_89AB_CDEF -> out_result equals rdata.
REQ-045 Back-to-back ALU entries with WB_allow_in=1 -> one transfer per cycle, no bubbles.
